// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM-subset pipeline: Val2 generator, ALU,
// NZCV status register and an iterative shift-add multiplier that stalls the pipe.
module exe_stage #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  exe_cmd,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic        s,
  input  logic        b,
  input  logic        imm,
  input  logic        carry_in,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic [31:0] pc,
  output logic [31:0] alu_result,
  output logic [31:0] br_addr,
  output logic        br_taken,
  output logic [3:0]  status,
  output logic        stall
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  mul_state_t       state, state_d;
  logic [63:0]      product;
  logic [63:0]      mcand;
  logic [31:0]      mplier;
  logic [CNT_W-1:0] counter;
  logic             stall_c;

  logic [31:0] val2;
  logic [31:0] op_b;
  logic        cin;
  logic        arith;
  logic [32:0] sum;
  logic        ovf;
  logic [31:0] result;
  logic [3:0]  flags;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  // Val2: rotated immediate, load/store offset, or shifted register
  always_comb begin
    val2 = val_rm;
    if (imm) begin
      val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_r || mem_w) begin
      val2 = {20'b0, shift_operand};
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2 = val_rm << shift_operand[11:7];
        2'b01:   val2 = val_rm >> shift_operand[11:7];
        2'b10:   val2 = 32'($signed(val_rm) >>> shift_operand[11:7]);
        default: val2 = ror32(val_rm, shift_operand[11:7]);
      endcase
    end
  end

  // Shared 33-bit adder: subtraction is a + ~b + carry, so C comes out as NOT borrow
  always_comb begin
    op_b  = val2;
    cin   = 1'b0;
    arith = 1'b0;
    case (exe_cmd)
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = carry_in; end
      CMD_SUB: begin arith = 1'b1; op_b = ~val2; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; op_b = ~val2; cin = carry_in; end
      default: ;
    endcase
  end

  assign sum = {1'b0, val_rn} + {1'b0, op_b} + 33'(cin);
  // With op_b already inverted for subtraction, one overflow rule covers both
  assign ovf = (val_rn[31] == op_b[31]) && (sum[31] != val_rn[31]);

  always_comb begin
    result = 32'h0;
    case (exe_cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: result = sum[31:0];
      CMD_AND: result = val_rn & val2;
      CMD_ORR: result = val_rn | val2;
      CMD_EOR: result = val_rn ^ val2;
      CMD_MUL: result = product[31:0];
      default: result = 32'h0;
    endcase
  end

  assign alu_result = result;
  assign flags = {result[31], (result == 32'h0),
                  arith ? sum[32] : status[1],
                  arith ? ovf     : status[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status <= 4'b0;
    end else if (s && !stall && (exe_cmd != CMD_NOP)) begin
      status <= flags;
    end
  end

  assign br_addr  = pc + {{6{signed_imm[23]}}, signed_imm, 2'b00};
  assign br_taken = b;

  // Multiplier state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    stall_c = 1'b0;
    case (state)
      IDLE: begin
        if (exe_cmd == CMD_MUL) begin
          stall_c = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (counter == CNT_W'(MUL_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset must drop the freeze even while a MUL is still presented
  assign stall = stall_c & rst;

  // Shift-add datapath, one multiplier bit per BUSY cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= 64'h0;
      mcand   <= 64'h0;
      mplier  <= 32'h0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exe_cmd == CMD_MUL) begin
            product <= 64'h0;
            mcand   <= {32'h0, val_rm};
            mplier  <= val_rn;
            counter <= '0;
          end
        end
        BUSY: begin
          if (mplier[0]) begin
            product <= product + mcand;
          end
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: vector table for single-cycle ops,
// hand sequences for multiply stall, reset abort and branch target.
module tb_exe_stage;

  localparam logic [3:0] NOP = 4'b0000, MOV = 4'b0001, ADD = 4'b0010, ADC = 4'b0011,
                         SUB = 4'b0100, SBC = 4'b0101, AND_ = 4'b0110, ORR = 4'b0111,
                         EOR = 4'b1000, MVN = 4'b1001, MUL = 4'b1010;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exe_cmd;
  logic        mem_r, mem_w, s, b, imm, carry_in;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm;
  logic [31:0] val_rn, val_rm, pc;
  logic [31:0] alu_result, br_addr;
  logic        br_taken, stall;
  logic [3:0]  status;

  int n_cmp = 0;
  int n_err = 0;

  exe_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .mem_r(mem_r), .mem_w(mem_w),
    .s(s), .b(b), .imm(imm), .carry_in(carry_in), .shift_operand(shift_operand),
    .signed_imm(signed_imm), .val_rn(val_rn), .val_rm(val_rm), .pc(pc),
    .alu_result(alu_result), .br_addr(br_addr), .br_taken(br_taken),
    .status(status), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic        s;
    logic        imm;
    logic        mem;
    logic        cin;
    logic [11:0] so;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_mul(input logic [31:0] rm, input logic [31:0] rn,
                         input logic [31:0] res, input logic [3:0] st_pre,
                         input logic [3:0] st_post);
    int cyc;
    @(negedge clk);
    exe_cmd = MUL; s = 1'b1; imm = 1'b0; mem_r = 1'b0; carry_in = 1'b0;
    shift_operand = 12'h0; val_rm = rm; val_rn = rn;
    cyc = 0;
    #1;
    while (stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    check("mul_stall_cycles", 32'(cyc), 32'd33);
    check("mul_done_stall", 32'(stall), 32'd0);
    check("mul_result", alu_result, res);
    check("mul_status_held", 32'(status), 32'(st_pre));
    @(posedge clk);
    #1;
    check("mul_status", 32'(status), 32'(st_post));
    exe_cmd = NOP; s = 1'b0;
  endtask

  initial begin
    rst = 1'b0; exe_cmd = NOP; mem_r = 1'b0; mem_w = 1'b0; s = 1'b0; b = 1'b0;
    imm = 1'b0; carry_in = 1'b0; shift_operand = 12'h0; signed_imm = 24'h0;
    val_rn = 32'h0; val_rm = 32'h0; pc = 32'h0;

    //            cmd  s     imm   mem   cin   so       rn            rm            res           st
    vecs[0]  = '{ADD, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 32'h7FFFFFFF, 32'h0,        32'h80000000, 4'b1001};
    vecs[1]  = '{SUB, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h5,        32'h5,        32'h0,        4'b0110};
    vecs[2]  = '{SUB, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h5,        32'h3,        32'h2,        4'b0110};
    vecs[3]  = '{ADC, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'h3,        32'h4,        32'h8,        4'b0110};
    vecs[4]  = '{SBC, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'hA,        32'h3,        32'h6,        4'b0110};
    vecs[5]  = '{MOV, 1'b1, 1'b0, 1'b0, 1'b0, 12'h260, 32'h0,        32'hF,        32'hF0000000, 4'b1010};
    vecs[6]  = '{MVN, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b1010};
    vecs[7]  = '{ADD, 1'b0, 1'b0, 1'b1, 1'b0, 12'h004, 32'h1000,     32'h0,        32'h00001004, 4'b1010};
    vecs[8]  = '{AND_,1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'hF0F0,     32'hFF00,     32'h0000F000, 4'b0010};
    vecs[9]  = '{ORR, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'hF0F0,     32'hFF00,     32'h0000FFF0, 4'b0010};
    vecs[10] = '{EOR, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'hF0F0,     32'hFF00,     32'h00000FF0, 4'b0010};
    vecs[11] = '{MOV, 1'b0, 1'b0, 1'b0, 1'b0, 12'hF80, 32'h0,        32'h1,        32'h80000000, 4'b0010};
    vecs[12] = '{MOV, 1'b0, 1'b0, 1'b0, 1'b0, 12'h240, 32'h0,        32'h80000000, 32'hF8000000, 4'b0010};
    vecs[13] = '{MOV, 1'b0, 1'b0, 1'b0, 1'b0, 12'h220, 32'h0,        32'h80000000, 32'h08000000, 4'b0010};
    vecs[14] = '{MOV, 1'b0, 1'b1, 1'b0, 1'b0, 12'h4FF, 32'h0,        32'h0,        32'hFF000000, 4'b0010};
    vecs[15] = '{NOP, 1'b1, 1'b0, 1'b0, 1'b1, 12'h123, 32'h12345678, 32'h9ABCDEF0, 32'h0,        4'b0010};
    vecs[16] = '{SUB, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0011};

    repeat (3) @(posedge clk);
    #1;
    check("reset_status", 32'(status), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      exe_cmd = vecs[i].cmd; s = vecs[i].s; imm = vecs[i].imm; mem_r = vecs[i].mem;
      carry_in = vecs[i].cin; shift_operand = vecs[i].so;
      val_rn = vecs[i].rn; val_rm = vecs[i].rm;
      #1;
      check($sformatf("v%0d_result", i), alu_result, vecs[i].res);
      check($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
      check($sformatf("v%0d_br_taken", i), 32'(br_taken), 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].st));
    end

    // Unsigned borrow: 0 - 1
    @(negedge clk);
    exe_cmd = SUB; s = 1'b1; imm = 1'b0; mem_r = 1'b0; shift_operand = 12'h0;
    val_rn = 32'h0; val_rm = 32'h1;
    #1;
    check("borrow_result", alu_result, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("borrow_status", 32'(status), 32'b1000);
    // Signed overflow on subtraction restores C=1,V=1 before the multiplies
    @(negedge clk);
    val_rn = 32'h80000000; val_rm = 32'h1;
    @(posedge clk);
    #1;
    check("subv_status", 32'(status), 32'b0011);

    run_mul(32'h12345, 32'h100, 32'h01234500, 4'b0011, 4'b0011);
    run_mul(32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 4'b0011, 4'b1011);

    // Reset in the middle of a multiply
    @(negedge clk);
    exe_cmd = MUL; s = 1'b1; val_rm = 32'h7; val_rn = 32'h9;
    repeat (5) @(posedge clk);
    #2;
    check("busy_stall", 32'(stall), 32'h1);
    rst = 1'b0;
    #1;
    check("abort_stall", 32'(stall), 32'h0);
    check("abort_status", 32'(status), 32'h0);
    exe_cmd = ADD; s = 1'b1; val_rn = 32'hFFFFFFFF; val_rm = 32'h1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_reset_add", alu_result, 32'h0);
    check("post_reset_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    check("post_reset_status", 32'(status), 32'b0110);

    // Branch target with negative offset
    @(negedge clk);
    exe_cmd = NOP; s = 1'b0; b = 1'b1; pc = 32'h100; signed_imm = 24'hFFFFFE;
    #1;
    check("br_taken", 32'(br_taken), 32'h1);
    check("br_addr", br_addr, 32'h000000F8);
    check("br_nop_result", alu_result, 32'h0);
    @(negedge clk);
    signed_imm = 24'h000010;
    #1;
    check("br_addr_fwd", br_addr, 32'h00000140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
